// File: rtl/branch_target_predictor.sv
`timescale 1ns/1ps
// Branch target buffer: tagged entries with saturating direction counters,
// combinational next-PC prediction, one resolved-branch update per cycle.
// Ports: clk, rst (sync, active-high) | lookup_pc -> pred_pc, pred_taken,
//   pred_hit | upd_valid, upd_pc, upd_taken, upd_target | busy (clear sweep).
// Option: define BTB_BYPASS_EN to forward a same-cycle update into lookup.
module branch_target_predictor #(
  parameter int ADDR_W  = 16,
  parameter int INDEX_W = 10,
  parameter int TAG_W   = 5,
  parameter int CTR_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_pc,
  output logic [ADDR_W-1:0] pred_pc,
  output logic              pred_taken,
  output logic              pred_hit,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  output logic              busy
);

  localparam int DEPTH = 1 << INDEX_W;
  localparam logic [INDEX_W-1:0] IDX_LAST = '1;
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [CTR_W-1:0] CTR_ZERO = '0;
  localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_ONE << (CTR_W - 1);

  if ((INDEX_W + TAG_W > ADDR_W - 1) || (CTR_W < 1)) begin : g_bad_cfg
    $error("branch_target_predictor: bad field widths");
  end

  typedef enum logic {CLEAR, READY} state_t;

  state_t state, state_next;
  logic [INDEX_W-1:0] clr_idx, clr_idx_next;

  logic              valid_mem  [DEPTH];
  logic [TAG_W-1:0]  tag_mem    [DEPTH];
  logic [ADDR_W-1:0] target_mem [DEPTH];
  logic [CTR_W-1:0]  ctr_mem    [DEPTH];

  logic [INDEX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0]   lk_tag, up_tag;

  assign lk_idx = lookup_pc[INDEX_W:1];
  assign lk_tag = lookup_pc[INDEX_W+TAG_W:INDEX_W+1];
  assign up_idx = upd_pc[INDEX_W:1];
  assign up_tag = upd_pc[INDEX_W+TAG_W:INDEX_W+1];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc, upd_pc};

  assign busy = (state == CLEAR);

  // Sweep state
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_next;
      clr_idx <= clr_idx_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    unique case (state)
      CLEAR: begin
        clr_idx_next = clr_idx + INDEX_W'(1);
        if (clr_idx == IDX_LAST) state_next = READY;
      end
      READY: ;
      default: state_next = CLEAR;
    endcase
  end

  // Update path: post-update image of the addressed entry
  logic              up_hit, up_en, up_wr;
  logic [CTR_W-1:0]  new_ctr;
  logic [ADDR_W-1:0] new_tgt;

  assign up_en  = upd_valid & ~busy;
  assign up_hit = valid_mem[up_idx] & (tag_mem[up_idx] == up_tag);

  always_comb begin
    up_wr   = 1'b0;
    new_ctr = ctr_mem[up_idx];
    new_tgt = target_mem[up_idx];
    if (up_en) begin
      unique case (1'b1)
        up_hit & upd_taken: begin
          up_wr   = 1'b1;
          new_tgt = upd_target;
          if (ctr_mem[up_idx] != CTR_MAX)
            new_ctr = ctr_mem[up_idx] + CTR_ONE;
        end
        up_hit & ~upd_taken: begin
          up_wr = 1'b1;
          if (ctr_mem[up_idx] != CTR_ZERO)
            new_ctr = ctr_mem[up_idx] - CTR_ONE;
        end
        ~up_hit & upd_taken: begin
          up_wr   = 1'b1;
          new_ctr = CTR_WEAK;
          new_tgt = upd_target;
        end
        default: ;
      endcase
    end
  end

  // Table writes: the sweep owns the table while busy
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (busy) begin
        valid_mem[clr_idx] <= 1'b0;
        ctr_mem[clr_idx]   <= '0;
      end else if (up_wr) begin
        valid_mem[up_idx]  <= 1'b1;
        tag_mem[up_idx]    <= up_tag;
        target_mem[up_idx] <= new_tgt;
        ctr_mem[up_idx]    <= new_ctr;
      end
    end
  end

  // Lookup path
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [ADDR_W-1:0] rd_tgt;
  logic [CTR_W-1:0]  rd_ctr;

`ifdef BTB_BYPASS_EN
  logic fwd;
  assign fwd = up_wr & (up_idx == lk_idx);

  always_comb begin
    rd_valid = valid_mem[lk_idx];
    rd_tag   = tag_mem[lk_idx];
    rd_tgt   = target_mem[lk_idx];
    rd_ctr   = ctr_mem[lk_idx];
    if (fwd) begin
      rd_valid = 1'b1;
      rd_tag   = up_tag;
      rd_tgt   = new_tgt;
      rd_ctr   = new_ctr;
    end
  end
`else
  always_comb begin
    rd_valid = valid_mem[lk_idx];
    rd_tag   = tag_mem[lk_idx];
    rd_tgt   = target_mem[lk_idx];
    rd_ctr   = ctr_mem[lk_idx];
  end
`endif

  assign pred_hit   = rd_valid & (rd_tag == lk_tag) & ~busy;
  assign pred_taken = pred_hit & rd_ctr[CTR_W-1];
  assign pred_pc    = pred_taken ? rd_tgt : lookup_pc + ADDR_W'(2);

endmodule

// File: tb/tb_branch_target_predictor.sv
`timescale 1ns/1ps
// Scoreboard bench for branch_target_predictor (default parameters).
// Driver queues expected lookup results; negedge monitor pops and compares.
module tb_branch_target_predictor;

`ifdef BTB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] lookup_pc = 16'h0;
  logic [15:0] pred_pc;
  logic        pred_taken;
  logic        pred_hit;
  logic        upd_valid = 1'b0;
  logic [15:0] upd_pc = 16'h0;
  logic        upd_taken = 1'b0;
  logic [15:0] upd_target = 16'h0;
  logic        busy;

  always #5 clk = ~clk;

  branch_target_predictor dut (
    .clk        (clk),
    .rst        (rst),
    .lookup_pc  (lookup_pc),
    .pred_pc    (pred_pc),
    .pred_taken (pred_taken),
    .pred_hit   (pred_hit),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .busy       (busy)
  );

  typedef struct {
    string       name;
    logic [15:0] pc;
    logic        hit;
    logic        taken;
    logic        bsy;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errs = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (pred_pc !== e.pc || pred_hit !== e.hit ||
          pred_taken !== e.taken || busy !== e.bsy) begin
        errs++;
        $display("FAIL %s: got pc=%h hit=%b tk=%b busy=%b want pc=%h hit=%b tk=%b busy=%b",
                 e.name, pred_pc, pred_hit, pred_taken, busy,
                 e.pc, e.hit, e.taken, e.bsy);
      end
    end
  end

  task automatic step(input string nm, input logic [15:0] lpc,
                      input logic [15:0] epc, input logic eh,
                      input logic et, input logic eb);
    exp_t e;
    lookup_pc = lpc;
    e.name = nm; e.pc = epc; e.hit = eh; e.taken = et; e.bsy = eb;
    q.push_back(e);
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  task automatic upd(input logic [15:0] pc, input logic tk,
                     input logic [15:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = tk;
    upd_target = tgt;
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    pulse_rst();
    // Full sweep; an update mid-sweep must be dropped
    for (int i = 0; i < 1024; i++) begin
      if (i == 10) upd(16'h0100, 1'b1, 16'h0500);
      step("sweep", 16'h0100, 16'h0102, 1'b0, 1'b0, 1'b1);
    end
    step("sweep_end", 16'h0100, 16'h0102, 1'b0, 1'b0, 1'b0);
    step("dropped_upd", 16'h0100, 16'h0102, 1'b0, 1'b0, 1'b0);

    // Allocate 0x0040 -> 0x0200 with same-cycle lookup
    upd(16'h0040, 1'b1, 16'h0200);
    step("alloc_same", 16'h0040, BYP ? 16'h0200 : 16'h0042, BYP, BYP, 1'b0);
    step("alloc_pred", 16'h0040, 16'h0200, 1'b1, 1'b1, 1'b0);

    // ctr 2 -> 1 -> 0 -> 0
    upd(16'h0040, 1'b0, 16'h0000);
    step("nt1_same", 16'h0040, BYP ? 16'h0042 : 16'h0200, 1'b1, !BYP, 1'b0);
    upd(16'h0040, 1'b0, 16'h0000);
    step("nt2", 16'h0040, 16'h0042, 1'b1, 1'b0, 1'b0);
    upd(16'h0040, 1'b0, 16'h0000);
    step("nt3", 16'h0040, 16'h0042, 1'b1, 1'b0, 1'b0);
    step("ctr0", 16'h0040, 16'h0042, 1'b1, 1'b0, 1'b0);
    // ctr 0 -> 1 -> 2
    upd(16'h0040, 1'b1, 16'h0200);
    step("t1", 16'h0040, 16'h0042, 1'b1, 1'b0, 1'b0);
    upd(16'h0040, 1'b1, 16'h0200);
    step("t2_same", 16'h0040, BYP ? 16'h0200 : 16'h0042, 1'b1, BYP, 1'b0);
    step("ctr2", 16'h0040, 16'h0200, 1'b1, 1'b1, 1'b0);
    // ctr 2 -> 3 -> 3 -> 2 -> 1
    upd(16'h0040, 1'b1, 16'h0200);
    step("t3", 16'h0040, 16'h0200, 1'b1, 1'b1, 1'b0);
    upd(16'h0040, 1'b1, 16'h0200);
    step("t_sat", 16'h0040, 16'h0200, 1'b1, 1'b1, 1'b0);
    upd(16'h0040, 1'b0, 16'h0000);
    step("nt_from3", 16'h0040, 16'h0200, 1'b1, 1'b1, 1'b0);
    step("ctr2b", 16'h0040, 16'h0200, 1'b1, 1'b1, 1'b0);
    upd(16'h0040, 1'b0, 16'h0000);
    step("nt_to1", 16'h0040, BYP ? 16'h0042 : 16'h0200, 1'b1, !BYP, 1'b0);
    step("ctr1", 16'h0040, 16'h0042, 1'b1, 1'b0, 1'b0);
    // Taken hit rewrites target
    upd(16'h0040, 1'b1, 16'h0280);
    step("retarget_same", 16'h0040, BYP ? 16'h0280 : 16'h0042, 1'b1, BYP, 1'b0);
    step("retarget", 16'h0040, 16'h0280, 1'b1, 1'b1, 1'b0);

    // Tag alias at the same index
    step("alias_miss", 16'h0840, 16'h0842, 1'b0, 1'b0, 1'b0);
    upd(16'h0840, 1'b1, 16'h0300);
    step("alias_same", 16'h0840, BYP ? 16'h0300 : 16'h0842, BYP, BYP, 1'b0);
    step("alias_hit", 16'h0840, 16'h0300, 1'b1, 1'b1, 1'b0);
    step("evicted", 16'h0040, 16'h0042, 1'b0, 1'b0, 1'b0);

    // Miss and not taken leaves the table alone
    upd(16'h0060, 1'b0, 16'h0700);
    step("miss_nt_same", 16'h0060, 16'h0062, 1'b0, 1'b0, 1'b0);
    step("miss_nt", 16'h0060, 16'h0062, 1'b0, 1'b0, 1'b0);

    // Fallthrough wraps
    step("wrap", 16'hFFFE, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Reset mid-sweep restarts the full sweep
    pulse_rst();
    for (int i = 0; i < 500; i++)
      step("sweep2", 16'h0840, 16'h0842, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    step("mid_rst", 16'h0840, 16'h0842, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    for (int i = 0; i < 1024; i++)
      step("sweep3", 16'h0840, 16'h0842, 1'b0, 1'b0, 1'b1);
    step("sweep3_end", 16'h0840, 16'h0842, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Parametrised branch target buffer with per-entry tags and saturating direction counters. It serves the fetch stage of the pipelined core. Each cycle it gives a same-cycle combinational next-PC prediction for the fetch PC. It takes one resolved-branch update per cycle from write-back. On reset, an internal sweep clears the whole table before predictions are enabled.

## Interface
Parameters:
- ADDR_W, 16: PC width in bits. PCs are halfword-aligned and bit 0 is ignored.
- INDEX_W, 10: table index width. Depth is 2^INDEX_W entries.
- TAG_W, 5: tag width. Elaboration requires INDEX_W + TAG_W <= ADDR_W - 1.
- CTR_W, 2: width of the saturating direction counter. Minimum is 1.

Ports:
- clk, input, 1: the single clock. All state changes on the rising edge.
- rst, input, 1: synchronous, active-high reset. Starts the clear sweep.
- lookup_pc, input, ADDR_W: fetch PC to predict from.
- pred_pc, output, ADDR_W: predicted next PC.
- pred_taken, output, 1: prediction is a taken branch.
- pred_hit, output, 1: lookup_pc matched a valid entry.
- upd_valid, input, 1: a branch has resolved this cycle.
- upd_pc, input, ADDR_W: PC of the resolved branch.
- upd_taken, input, 1: the resolved direction.
- upd_target, input, ADDR_W: the resolved target. Used only when upd_taken=1.
- busy, output, 1: the clear sweep is in progress. Lookups return fallthrough and updates are dropped.

## Operation
- Address fields are the same for lookups and updates:
  - index = pc[INDEX_W:1]
  - tag = pc[INDEX_W+TAG_W:INDEX_W+1]
- Each entry holds {valid, tag[TAG_W], target[ADDR_W], ctr[CTR_W]}.
- Lookup is purely combinational from lookup_pc and the table state:
  - hit = valid & (tag == lookup tag) & !busy.
  - taken = hit & ctr[CTR_W-1].
  - pred_pc = taken ? target : lookup_pc + 2. The add is truncated to ADDR_W, so 0xFFFE+2 gives 0x0000.
- Update, when upd_valid & !busy:
  - Hit and taken: ctr = min(ctr+1, 2^CTR_W-1). target = upd_target.
  - Hit and not taken: ctr = max(ctr-1, 0). target is unchanged.
  - Miss and taken: allocate. valid=1, tag and target are written, ctr = 2^(CTR_W-1) (weakly taken). Any entry at that index is overwritten; there is no replacement policy.
  - Miss and not taken: no change.
- State machine with two states, CLEAR and READY:
  - Any cycle with rst=1 moves to CLEAR with clr_idx=0. This includes a reset mid-sweep, which restarts at index 0.
  - In CLEAR, each cycle sets valid=0 and ctr=0 at clr_idx, then clr_idx increments.
  - When clr_idx = 2^INDEX_W-1 has been cleared, the state moves to READY.
  - In READY, normal operation. There is no way back to CLEAR except rst.
- busy = (state == CLEAR). While busy: pred_hit=0, pred_taken=0, pred_pc = lookup_pc+2, and upd_valid is ignored.

## Timing
- Values after the rst edge: busy=1, and pred_hit and pred_taken are 0. busy stays 1 for exactly 2^INDEX_W cycles after rst deasserts; that is 1024 with defaults.
- Before the first rst, all outputs are undefined.
- Lookup latency is 0 cycles (combinational). The update takes effect at the next rising edge.
- A lookup and an update to the same index in the same cycle: the lookup returns the pre-update contents, unless BTB_BYPASS_EN is defined.
- Back-to-back updates to the same entry on consecutive cycles each see the previous result. There is no lost update.

## Configuration
- BTB_BYPASS_EN defined:
  - A same-cycle update whose index matches lookup_pc is forwarded into the lookup result. pred_hit, pred_taken and pred_pc reflect the post-update entry, computed with the same counter and allocation rules.
  - This adds a comparator and mux on the lookup path.
- Not defined: no forwarding. The lookup always reads the registered table.

## Test plan
- Reset sweep: assert rst for 1 cycle with defaults. Require busy=1 for 1024 cycles then 0. During the sweep, lookup_pc=0x0100 gives pred_pc=0x0102 with pred_hit=0. An upd_valid during the sweep is dropped, so the same lookup after the sweep still misses.
- Allocate and predict: upd pc=0x0040, taken, target=0x0200. The next cycle, lookup 0x0040 gives hit=1, taken=1, pred_pc=0x0200.
- Counter hysteresis:
  - After allocation (ctr=2), one not-taken gives ctr=1 and taken=0 with pred_pc=0x0042.
  - A second not-taken gives ctr=0. A third not-taken stays at 0.
  - Two taken updates then give ctr=2 and the prediction is taken again.
- Tag alias: allocate 0x0040→0x0200, then lookup 0x0840 (same index, different tag). Require hit=0 and pred_pc=0x0842. A taken update at 0x0840 with target 0x0300 overwrites the entry, and 0x0040 now misses.
- Wrap: lookup 0xFFFE on a miss gives pred_pc=0x0000.
- Reset mid-sweep and bypass:
  - rst pulse at sweep cycle 500: busy continues for a full 1024 more cycles.
  - With BTB_BYPASS_EN: update 0x0040 taken→0x0200 while looking up 0x0040 in the same cycle gives pred_pc=0x0200 that cycle. Without the macro it gives 0x0042.
